// File: rtl/waveform_analyzer.sv
// Measures min/max, peak-to-peak and period of an 8-bit sampled waveform.
// The period is taken between two hysteretic rising crossings of the min/max midpoint.
module waveform_analyzer #(
    parameter int WINDOW   = 65536,
    parameter int HYST     = 4,
    parameter int PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          Waveform,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [7:0]          Max,
    output logic [7:0]          Min,
    output logic [7:0]          Amplitude,
    output logic [PERIOD_W-1:0] Period,
    output logic                flat,
    output logic                timeout
);
    localparam int AW = $clog2(WINDOW);
    localparam logic [AW-1:0]       ACQ_LAST = AW'(WINDOW - 1);
    localparam logic [PERIOD_W-1:0] CNT_MAX  = {PERIOD_W{1'b1}};
    localparam logic [7:0]          HYST8    = 8'(HYST);
    localparam logic [8:0]          FLAT_LIM = 9'(2 * HYST);

    typedef enum logic [2:0] {
        S_IDLE, S_ACQUIRE, S_THRESH, S_WAIT_FIRST, S_MEASURE, S_DONE
    } state_t;

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    function automatic logic [7:0] sat_sub8(input logic [7:0] a, input logic [7:0] b);
        return (a < b) ? 8'h00 : (a - b);
    endfunction

    state_t              state_q, state_d;
    logic [AW-1:0]       acq_cnt_q, acq_cnt_d;
    logic [7:0]          run_min_q, run_min_d, run_max_q, run_max_d;
    logic [7:0]          hi_q, hi_d, lo_q, lo_d;
    logic                armed_q, armed_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] res_period_q, res_period_d;
    logic                res_flat_q, res_flat_d, res_timeout_q, res_timeout_d;
    logic                done_q, done_d;
    logic [7:0]          max_q, max_d, min_q, min_d, amp_q, amp_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic                flat_q, flat_d, timeout_q, timeout_d;

    logic [7:0] mid_w, span_w;
    logic       event_w;

    assign mid_w   = 8'(({1'b0, run_max_q} + {1'b0, run_min_q}) >> 1);
    assign span_w  = run_max_q - run_min_q;
    assign event_w = armed_q && (Waveform >= hi_q);

    always_comb begin
        state_d       = state_q;
        acq_cnt_d     = acq_cnt_q;
        run_min_d     = run_min_q;
        run_max_d     = run_max_q;
        hi_d          = hi_q;
        lo_d          = lo_q;
        armed_d       = armed_q;
        cnt_d         = cnt_q;
        res_period_d  = res_period_q;
        res_flat_d    = res_flat_q;
        res_timeout_d = res_timeout_q;
        done_d        = 1'b0;
        max_d         = max_q;
        min_d         = min_q;
        amp_d         = amp_q;
        period_d      = period_q;
        flat_d        = flat_q;
        timeout_d     = timeout_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d       = S_ACQUIRE;
                    run_min_d     = 8'hFF;
                    run_max_d     = 8'h00;
                    acq_cnt_d     = '0;
                    cnt_d         = '0;
                    res_flat_d    = 1'b0;
                    res_timeout_d = 1'b0;
                end
            end
            S_ACQUIRE: begin
                if (Waveform < run_min_q) run_min_d = Waveform;
                if (Waveform > run_max_q) run_max_d = Waveform;
                acq_cnt_d = acq_cnt_q + 1'b1;
                if (acq_cnt_q == ACQ_LAST) state_d = S_THRESH;
            end
            S_THRESH: begin
                hi_d    = sat_add8(mid_w, HYST8);
                lo_d    = sat_sub8(mid_w, HYST8);
                armed_d = 1'b0;
                cnt_d   = '0;
                if ({1'b0, span_w} < FLAT_LIM) begin
                    res_flat_d   = 1'b1;
                    res_period_d = '0;
                    state_d      = S_DONE;
                end else begin
                    state_d = S_WAIT_FIRST;
                end
            end
            S_WAIT_FIRST, S_MEASURE: begin
                // An event wins over the terminal count on the same cycle.
                if (event_w) begin
                    armed_d = 1'b0;
                    if (state_q == S_WAIT_FIRST) begin
                        cnt_d   = {{(PERIOD_W-1){1'b0}}, 1'b1};
                        state_d = S_MEASURE;
                    end else begin
                        res_period_d = cnt_q;
                        state_d      = S_DONE;
                    end
                end else begin
                    if (Waveform <= lo_q) armed_d = 1'b1;
                    if (cnt_q == CNT_MAX) begin
                        res_timeout_d = 1'b1;
                        res_period_d  = CNT_MAX;
                        state_d       = S_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                done_d    = 1'b1;
                max_d     = run_max_q;
                min_d     = run_min_q;
                amp_d     = span_w;
                period_d  = res_period_q;
                flat_d    = res_flat_q;
                timeout_d = res_timeout_q;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            acq_cnt_q     <= '0;
            run_min_q     <= 8'hFF;
            run_max_q     <= 8'h00;
            hi_q          <= 8'h00;
            lo_q          <= 8'h00;
            armed_q       <= 1'b0;
            cnt_q         <= '0;
            res_period_q  <= '0;
            res_flat_q    <= 1'b0;
            res_timeout_q <= 1'b0;
            done_q        <= 1'b0;
            max_q         <= 8'h00;
            min_q         <= 8'h00;
            amp_q         <= 8'h00;
            period_q      <= '0;
            flat_q        <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            acq_cnt_q     <= acq_cnt_d;
            run_min_q     <= run_min_d;
            run_max_q     <= run_max_d;
            hi_q          <= hi_d;
            lo_q          <= lo_d;
            armed_q       <= armed_d;
            cnt_q         <= cnt_d;
            res_period_q  <= res_period_d;
            res_flat_q    <= res_flat_d;
            res_timeout_q <= res_timeout_d;
            done_q        <= done_d;
            max_q         <= max_d;
            min_q         <= min_d;
            amp_q         <= amp_d;
            period_q      <= period_d;
            flat_q        <= flat_d;
            timeout_q     <= timeout_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign Max       = max_q;
    assign Min       = min_q;
    assign Amplitude = amp_q;
    assign Period    = period_q;
    assign flat      = flat_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_waveform_analyzer.sv
// Randomized-phase bench for waveform_analyzer: every measurement is compared with a
// reference computed from the recorded sample history.
module tb_waveform_analyzer;
    localparam int W      = 256;
    localparam int H      = 4;
    localparam int BUDGET = 3000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_a = 1'b0, start_b = 1'b0;
    logic [7:0] Waveform = 8'h00;

    logic        busy_a, done_a, flat_a, to_a;
    logic [7:0]  max_a, min_a, amp_a;
    logic [23:0] per_a;
    logic        busy_b, done_b, flat_b, to_b;
    logic [7:0]  max_b, min_b, amp_b;
    logic [7:0]  per_b;

    always #5 clk = ~clk;

    waveform_analyzer #(.WINDOW(W), .HYST(H), .PERIOD_W(24)) dut_a (
        .clk(clk), .reset(reset), .Waveform(Waveform), .start(start_a),
        .busy(busy_a), .done(done_a), .Max(max_a), .Min(min_a), .Amplitude(amp_a),
        .Period(per_a), .flat(flat_a), .timeout(to_a)
    );

    waveform_analyzer #(.WINDOW(W), .HYST(H), .PERIOD_W(8)) dut_b (
        .clk(clk), .reset(reset), .Waveform(Waveform), .start(start_b),
        .busy(busy_b), .done(done_b), .Max(max_b), .Min(min_b), .Amplitude(amp_b),
        .Period(per_b), .flat(flat_b), .timeout(to_b)
    );

    int     n_checks = 0;
    int     n_fail   = 0;
    int     mode = 0, ph = 0, kk = 0;
    bit     sel = 1'b0;
    int     samp[$];
    longint prev_max[2] = '{0, 0};
    longint prev_per[2] = '{0, 0};

    logic        busy_s, done_s, flat_s, to_s;
    logic [7:0]  max_s, min_s, amp_s;
    logic [23:0] per_s;
    assign busy_s = sel ? busy_b : busy_a;
    assign done_s = sel ? done_b : done_a;
    assign flat_s = sel ? flat_b : flat_a;
    assign to_s   = sel ? to_b   : to_a;
    assign max_s  = sel ? max_b  : max_a;
    assign min_s  = sel ? min_b  : min_a;
    assign amp_s  = sel ? amp_b  : amp_a;
    assign per_s  = sel ? {16'h0, per_b} : per_a;

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int gen(input int t);
        int p;
        case (mode)
            0: return ((t % 40) < 20) ? 200 : 0;
            1: return t % 256;
            2: return 128;
            3: begin
                p = t % 500;
                return (p <= 250) ? p : 500 - p;
            end
            4: begin
                p = ((t % 60) < 30) ? 150 : 50;
                return p + int'($urandom_range(0, 6)) - 3;
            end
            default: return int'($urandom_range(0, 255));
        endcase
    endfunction

    // samp[k] is the sample present at edge k, edge 0 being the accepting edge.
    task automatic tick();
        samp.push_back(int'(Waveform));
        @(posedge clk);
        #1;
        kk++;
        Waveform = 8'(gen(kk + ph));
    endtask

    task automatic model(input int pw, output longint e_max, output longint e_min,
                         output longint e_amp, output longint e_per, output longint e_flat,
                         output longint e_to, output longint e_done);
        int mx, mn, mid, hi, lo, lim, t1;
        bit armed, fin, ev;
        mx = 0; mn = 255;
        e_flat = 0; e_to = 0; e_per = 0; e_done = -2;
        for (int k = 1; k <= W && k < samp.size(); k++) begin
            if (samp[k] > mx) mx = samp[k];
            if (samp[k] < mn) mn = samp[k];
        end
        e_max = mx; e_min = mn; e_amp = mx - mn;
        mid = (mx + mn) / 2;
        hi  = (mid + H > 255) ? 255 : mid + H;
        lo  = (mid - H < 0) ? 0 : mid - H;
        lim = (1 << pw) - 1;
        if (mx - mn < 2 * H) begin
            e_flat = 1;
            e_done = W + 2;
        end else begin
            armed = 0; t1 = -1; fin = 0;
            for (int k = W + 2; k < samp.size() && !fin; k++) begin
                ev = armed && (samp[k] >= hi);
                if (ev) begin
                    armed = 0;
                    if (t1 < 0) t1 = k;
                    else begin e_per = k - t1; e_done = k + 1; fin = 1; end
                end else begin
                    if (samp[k] <= lo) armed = 1;
                    if ((t1 < 0 && k - (W + 2) == lim) || (t1 >= 0 && k - t1 == lim)) begin
                        e_to = 1; e_per = lim; e_done = k + 1; fin = 1;
                    end
                end
            end
        end
    endtask

    task automatic run_meas(input bit use_b, input int md, input bit inject,
                            output longint r_max, output longint r_min, output longint r_amp,
                            output longint r_per, output longint r_flat, output longint r_to,
                            output longint r_lat);
        int dk, overlap;
        longint e_max, e_min, e_amp, e_per, e_flat, e_to, e_done;
        dk = -1; overlap = 0;
        sel = use_b; mode = md; ph = int'($urandom_range(0, 999));
        samp.delete(); kk = 0;
        Waveform = 8'(gen(ph));
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
        tick();
        start_a = 1'b0; start_b = 1'b0;
        check_val("busy_accept", busy_s, 1);
        for (int k = 1; k <= BUDGET; k++) begin
            if (inject && (k == 10 || k == 100)) begin
                if (use_b) start_b = 1'b1; else start_a = 1'b1;
            end else begin
                start_a = 1'b0; start_b = 1'b0;
            end
            tick();
            if (k == 3) begin
                check_val("hold_max", max_s, prev_max[use_b]);
                check_val("hold_period", per_s, prev_per[use_b]);
            end
            if (busy_s && done_s) overlap++;
            if (done_s) begin dk = k; break; end
        end
        start_a = 1'b0; start_b = 1'b0;
        check_val("done_seen", longint'(dk >= 0), 1);
        check_val("busy_done_overlap", overlap, 0);
        model(use_b ? 8 : 24, e_max, e_min, e_amp, e_per, e_flat, e_to, e_done);
        check_val("done_latency", dk, e_done);
        check_val("busy_at_done", busy_s, 0);
        check_val("max", max_s, e_max);
        check_val("min", min_s, e_min);
        check_val("amplitude", amp_s, e_amp);
        check_val("period", per_s, e_per);
        check_val("flat", flat_s, e_flat);
        check_val("timeout", to_s, e_to);
        r_max = max_s; r_min = min_s; r_amp = amp_s; r_per = per_s;
        r_flat = flat_s; r_to = to_s; r_lat = dk;
        tick();
        check_val("done_pulse_width", done_s, 0);
        prev_max[use_b] = e_max;
        prev_per[use_b] = e_per;
    endtask

    initial begin
        longint mx, mn, am, pr, fl, to, lat;
        longint s_max, s_min, s_per;
        int seen;

        repeat (3) tick();
        sel = 1'b0;
        check_val("rst_busy", busy_a, 0);
        check_val("rst_done", done_a, 0);
        check_val("rst_max", max_a, 0);
        check_val("rst_min", min_a, 0);
        check_val("rst_period", per_a, 0);
        check_val("rst_flat", flat_a, 0);
        check_val("rst_timeout", to_a, 0);
        reset = 1'b0;
        tick();

        run_meas(1'b0, 0, 1'b0, mx, mn, am, pr, fl, to, lat);
        check_val("square_max", mx, 200);
        check_val("square_min", mn, 0);
        check_val("square_amp", am, 200);
        check_val("square_period", pr, 40);

        run_meas(1'b0, 1, 1'b0, mx, mn, am, pr, fl, to, lat);
        s_max = mx; s_min = mn; s_per = pr;
        check_val("saw_max", mx, 255);
        check_val("saw_period", pr, 256);
        run_meas(1'b0, 1, 1'b0, mx, mn, am, pr, fl, to, lat);
        check_val("saw_repeat_max", mx, s_max);
        check_val("saw_repeat_min", mn, s_min);
        check_val("saw_repeat_period", pr, s_per);

        run_meas(1'b0, 2, 1'b0, mx, mn, am, pr, fl, to, lat);
        check_val("const_flat", fl, 1);
        check_val("const_period", pr, 0);
        check_val("const_amp", am, 0);
        check_val("const_latency", lat, W + 2);

        run_meas(1'b1, 3, 1'b0, mx, mn, am, pr, fl, to, lat);
        check_val("tri_timeout", to, 1);
        check_val("tri_period", pr, 255);

        run_meas(1'b0, 4, 1'b0, mx, mn, am, pr, fl, to, lat);
        check_val("noisy_period", pr, 60);

        repeat (2) run_meas(1'b0, 5, 1'b0, mx, mn, am, pr, fl, to, lat);

        run_meas(1'b0, 0, 1'b1, mx, mn, am, pr, fl, to, lat);
        check_val("inject_period", pr, 40);

        // Square with phase 0: first event at edge 280, second due at 320.
        sel = 1'b0; mode = 0; ph = 0; samp.delete(); kk = 0;
        Waveform = 8'(gen(0));
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int k = 1; k <= 290; k++) tick();
        reset = 1'b1;
        #1;
        check_val("mid_rst_busy", busy_a, 0);
        check_val("mid_rst_done", done_a, 0);
        check_val("mid_rst_max", max_a, 0);
        check_val("mid_rst_amp", amp_a, 0);
        check_val("mid_rst_period", per_a, 0);
        check_val("mid_rst_b_period", per_b, 0);
        check_val("mid_rst_b_timeout", to_b, 0);
        tick();
        reset = 1'b0;
        seen = 0;
        repeat (700) begin
            tick();
            seen += int'(done_a | busy_a);
        end
        check_val("no_done_after_reset", seen, 0);
        prev_max = '{0, 0};
        prev_per = '{0, 0};

        run_meas(1'b0, 0, 1'b0, mx, mn, am, pr, fl, to, lat);
        check_val("post_reset_period", pr, 40);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
